// File: rtl/hash_table_lookup.sv
// Hash-indexed exact-match table: lookup / insert / delete on a direct-mapped store.
// Latency: accept at edge T -> response at T+3 (no write) or T+4 (with write); one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, no new request meanwhile.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   init_done           table clear finished (sticky until next rst)
//   req_valid/req_ready request handshake; req_op/req_key/req_value request payload
//   rsp_valid/rsp_ready response handshake; rsp_hit/rsp_status/rsp_value response payload
module hash_table_lookup #(
    parameter int KEY_NBITS   = 32,
    parameter int HASH_NBITS  = 8,
    parameter int VALUE_NBITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_done,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_NBITS-1:0]   req_key,
    input  logic [VALUE_NBITS-1:0] req_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic [1:0]             rsp_status,
    output logic [VALUE_NBITS-1:0] rsp_value
);

    localparam int DEPTH    = 2 ** HASH_NBITS;
    localparam int ENTRY_W  = 1 + KEY_NBITS + VALUE_NBITS;
    localparam int NCHUNK   = (KEY_NBITS + HASH_NBITS - 1) / HASH_NBITS;
    // Entry layout: {valid, key, value}
    localparam int VLD_BIT  = ENTRY_W - 1;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_MISS   = 2'b01;
    localparam logic [1:0] ST_COLL   = 2'b10;
    localparam logic [1:0] ST_BADOP  = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_HASH,
        S_READ,
        S_CMP,
        S_WRITE,
        S_RESP
    } state_t;

    // Key hash: XOR-fold of the zero-padded key into HASH_NBITS-wide chunks.
    function automatic logic [HASH_NBITS-1:0] hash_eval(input logic [KEY_NBITS-1:0] k);
        logic [NCHUNK*HASH_NBITS-1:0] padded;
        logic [HASH_NBITS-1:0]        h;
        padded = '0;
        padded[KEY_NBITS-1:0] = k;
        h = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            h = h ^ padded[i*HASH_NBITS +: HASH_NBITS];
        end
        return h;
    endfunction

    state_t                  state_q, state_d;
    logic [HASH_NBITS-1:0]   init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic [1:0]              op_q, op_d;
    logic [KEY_NBITS-1:0]    key_q, key_d;
    logic [VALUE_NBITS-1:0]  val_q, val_d;
    logic [HASH_NBITS-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0]      wr_dat_q, wr_dat_d;
    logic                    hit_q, hit_d;
    logic [1:0]              status_q, status_d;
    logic [VALUE_NBITS-1:0]  value_q, value_d;

    // Single-port storage, synchronous read
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [ENTRY_W-1:0]      rd_q;
    logic [HASH_NBITS-1:0]   mem_addr;
    logic                    mem_we;
    logic                    mem_re;
    logic [ENTRY_W-1:0]      mem_wdat;

    // Fields of the entry read for the current request
    logic                    ent_vld;
    logic [KEY_NBITS-1:0]    ent_key;
    logic [VALUE_NBITS-1:0]  ent_val;
    logic                    match;

    assign ent_vld = rd_q[VLD_BIT];
    assign ent_key = rd_q[VALUE_NBITS +: KEY_NBITS];
    assign ent_val = rd_q[VALUE_NBITS-1:0];
    assign match   = ent_vld && (ent_key == key_q);

    // Init sweep and the WRITE state share the one port with READ
    assign mem_addr = (state_q == S_INIT) ? init_cnt_q : idx_q;
    assign mem_we   = (state_q == S_INIT) || (state_q == S_WRITE);
    assign mem_re   = (state_q == S_READ);
    assign mem_wdat = (state_q == S_INIT) ? '0 : wr_dat_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
        if (mem_re) begin
            rd_q <= mem[mem_addr];
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        op_d        = op_q;
        key_d       = key_q;
        val_d       = val_q;
        idx_d       = idx_q;
        wr_dat_d    = wr_dat_q;
        hit_d       = hit_q;
        status_d    = status_q;
        value_d     = value_q;

        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == HASH_NBITS'(DEPTH - 1)) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    key_d   = req_key;
                    val_d   = req_value;
                    state_d = S_HASH;
                end
            end
            S_HASH: begin
                idx_d   = hash_eval(key_q);
                state_d = S_READ;
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // Defaults cover MISS / COLLISION / BAD_OP: no hit, zero value, no write
                hit_d   = 1'b0;
                value_d = '0;
                state_d = S_RESP;
                unique case (op_q)
                    OP_LOOKUP: begin
                        if (match) begin
                            hit_d    = 1'b1;
                            status_d = ST_OK;
                            value_d  = ent_val;
                        end else begin
                            status_d = ST_MISS;
                        end
                    end
                    OP_INSERT: begin
                        if (match || !ent_vld) begin
                            hit_d    = match;
                            status_d = ST_OK;
                            value_d  = match ? ent_val : '0;
                            wr_dat_d = {1'b1, key_q, val_q};
                            state_d  = S_WRITE;
                        end else begin
                            status_d = ST_COLL;
                        end
                    end
                    OP_DELETE: begin
                        if (match) begin
                            hit_d    = 1'b1;
                            status_d = ST_OK;
                            value_d  = ent_val;
                            wr_dat_d = {1'b0, ent_key, ent_val};
                            state_d  = S_WRITE;
                        end else begin
                            status_d = ST_MISS;
                        end
                    end
                    default: begin
                        status_d = ST_BADOP;
                    end
                endcase
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            op_q        <= '0;
            key_q       <= '0;
            val_q       <= '0;
            idx_q       <= '0;
            wr_dat_q    <= '0;
            hit_q       <= 1'b0;
            status_q    <= 2'b00;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            op_q        <= op_d;
            key_q       <= key_d;
            val_q       <= val_d;
            idx_q       <= idx_d;
            wr_dat_q    <= wr_dat_d;
            hit_q       <= hit_d;
            status_q    <= status_d;
            value_q     <= value_d;
        end
    end

    assign init_done  = init_done_q;
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_hit    = hit_q;
    assign rsp_status = status_q;
    assign rsp_value  = value_q;

endmodule

// File: tb/tb_hash_table_lookup.sv
// Directed bench for hash_table_lookup (KEY 32, HASH 8, VALUE 16).
// Hash is an XOR-fold of the key bytes: 0x00000012 and 0x00001200 both map to index 0x12.
module tb_hash_table_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_key;
    logic [15:0] req_value;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_value;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] K1 = 32'h0000_0012;
    localparam logic [31:0] K2 = 32'h0000_1200;
    localparam logic [31:0] K3 = 32'h00AB_CDEF;

    always #5 clk = ~clk;

    hash_table_lookup #(
        .KEY_NBITS  (32),
        .HASH_NBITS (8),
        .VALUE_NBITS(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_value (req_value),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_status(rsp_status),
        .rsp_value (rsp_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Release reset on a falling edge and count rising edges until init_done.
    task automatic release_and_init(input string tag);
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 255) begin
                chk({tag, ":req_ready_low_during_init"}, {31'd0, req_ready}, 32'd0);
            end
        end
        chk({tag, ":init_cycles"}, n, 32'd256);
        chk({tag, ":req_ready_after_init"}, {31'd0, req_ready}, 32'd1);
    endtask

    // One request: checks acceptance, response latency, payload and the return to IDLE.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] key,
                          input logic [15:0] val, input int lat, input logic ehit,
                          input logic [1:0] est, input logic [15:0] evalue);
        int n;
        @(negedge clk);
        chk({tag, ":req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = '0;
        req_value = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ":latency"}, n, lat);
        chk({tag, ":hit"}, {31'd0, rsp_hit}, {31'd0, ehit});
        chk({tag, ":status"}, {30'd0, rsp_status}, {30'd0, est});
        chk({tag, ":value"}, {16'd0, rsp_value}, {16'd0, evalue});
        if (rsp_ready) begin
            @(posedge clk);
            #1;
            chk({tag, ":rsp_valid_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
            chk({tag, ":req_ready_next"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = '0;
        req_value = '0;
        rsp_ready = 1'b1;
        #1;
        chk("reset:init_done", {31'd0, init_done}, 32'd0);
        chk("reset:req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset:rsp_hit", {31'd0, rsp_hit}, 32'd0);
        chk("reset:rsp_status", {30'd0, rsp_status}, 32'd0);
        chk("reset:rsp_value", {16'd0, rsp_value}, 32'd0);
        repeat (3) @(posedge clk);

        release_and_init("init1");

        // Empty table
        do_req("lookup_empty", 2'b00, 32'h5, 16'h0, 3, 1'b0, 2'b01, 16'h0000);

        // Insert then lookup
        do_req("ins_k1", 2'b01, K1, 16'h1234, 4, 1'b0, 2'b00, 16'h0000);
        do_req("look_k1", 2'b00, K1, 16'h0, 3, 1'b1, 2'b00, 16'h1234);

        // Update returns old value; colliding key refused
        do_req("upd_k1", 2'b01, K1, 16'hBEEF, 4, 1'b1, 2'b00, 16'h1234);
        do_req("coll_k2", 2'b01, K2, 16'h5555, 3, 1'b0, 2'b10, 16'h0000);
        do_req("look_k1_after_coll", 2'b00, K1, 16'h0, 3, 1'b1, 2'b00, 16'hBEEF);
        do_req("look_k2_miss", 2'b00, K2, 16'h0, 3, 1'b0, 2'b01, 16'h0000);

        // Delete
        do_req("del_k1", 2'b10, K1, 16'h0, 4, 1'b1, 2'b00, 16'hBEEF);
        do_req("look_k1_deleted", 2'b00, K1, 16'h0, 3, 1'b0, 2'b01, 16'h0000);
        do_req("del_k1_again", 2'b10, K1, 16'h0, 3, 1'b0, 2'b01, 16'h0000);

        // Slot freed by delete accepts the previously colliding key
        do_req("ins_k2_free", 2'b01, K2, 16'h7777, 4, 1'b0, 2'b00, 16'h0000);
        do_req("look_k2", 2'b00, K2, 16'h0, 3, 1'b1, 2'b00, 16'h7777);

        // BAD_OP under backpressure
        @(negedge clk);
        rsp_ready = 1'b0;
        do_req("badop", 2'b11, K2, 16'hFFFF, 3, 1'b0, 2'b11, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d:rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_hold%0d:status", i), {30'd0, rsp_status}, 32'd3);
            chk($sformatf("bp_hold%0d:req_ready", i), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release:req_ready", {31'd0, req_ready}, 32'd1);

        // BAD_OP did not disturb the table
        do_req("look_k2_after_badop", 2'b00, K2, 16'h0, 3, 1'b1, 2'b00, 16'h7777);

        // Reset in the middle of an insert
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_key   = K3;
        req_value = 16'hCAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst:init_done", {31'd0, init_done}, 32'd0);
        chk("midrst:req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst:rsp_status", {30'd0, rsp_status}, 32'd0);
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) n++;
        end
        chk("midrst:no_response", n, 32'd0);

        release_and_init("init2");
        do_req("look_k3_after_rst", 2'b00, K3, 16'h0, 3, 1'b0, 2'b01, 16'h0000);
        do_req("look_k1_after_rst", 2'b00, K1, 16'h0, 3, 1'b0, 2'b01, 16'h0000);
        do_req("look_k2_after_rst", 2'b00, K2, 16'h0, 3, 1'b0, 2'b01, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
